// File: rtl/hcsr04_responder_if.sv
// Ranging bus between a ranging initiator (master) and the emulated HC-SR04 responder (slave).
interface hcsr04_responder_if;
   logic       trigger;
   logic [8:0] distance_cm;
   logic       echo;
   logic       busy;
   logic       short_trig;

   modport master (
      output trigger,
      output distance_cm,
      input  echo,
      input  busy,
      input  short_trig
   );

   modport slave (
      input  trigger,
      input  distance_cm,
      output echo,
      output busy,
      output short_trig
   );
endinterface

// File: rtl/hcsr04_responder.sv
// Emulated HC-SR04 ultrasonic sensor: answers a trigger pulse with a distance-proportional echo.
// Optional macro HCSR04_RESP_RANGE_CHECK_EN turns out-of-range distances into a timeout-width echo.
module hcsr04_responder #(
   parameter int unsigned CYCLES_PER_CM   = 2900,
   parameter int unsigned TRIG_MIN_CYCLES = 500,
   parameter int unsigned BURST_CYCLES    = 10000,
   parameter int unsigned HOLDOFF_CYCLES  = 500000,
   parameter int unsigned MAX_CM          = 400,
   parameter int unsigned TIMEOUT_CYCLES  = 1900000
) (
   input logic               clk,
   input logic               reset,
   hcsr04_responder_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARMED   = 3'd1,
      BURST   = 3'd2,
      ECHO    = 3'd3,
      HOLDOFF = 3'd4
   } state_t;

   state_t      state_r;
   state_t      state_nxt_s;
   logic [21:0] cnt_r;
   logic [21:0] cnt_nxt_s;
   logic [8:0]  latched_cm_r;
   logic [8:0]  latched_nxt_s;
   logic        sync1_r;
   logic        trig_s;
   logic        trig_prev_r;
   logic        trig_rise_s;
   logic        short_nxt_s;
   logic        echo_r;
   logic        busy_r;
   logic        short_trig_r;
   logic [21:0] echo_len_s;

`ifdef HCSR04_RESP_RANGE_CHECK_EN
   function automatic logic [21:0] echo_cycles(input logic [8:0] cm);
      logic [21:0] prod;
      prod = 22'(cm) * 22'(CYCLES_PER_CM);
      if ((cm == 9'd0) || (32'(cm) > MAX_CM)) begin
         return 22'(TIMEOUT_CYCLES);
      end else begin
         return prod;
      end
   endfunction
`else
   // Range limits only matter when the range check is built in.
   localparam logic [21:0] unused_range_cfg = 22'(MAX_CM) ^ 22'(TIMEOUT_CYCLES);

   function automatic logic [21:0] echo_cycles(input logic [8:0] cm);
      return 22'(cm) * 22'(CYCLES_PER_CM);
   endfunction
`endif

   assign echo_len_s  = echo_cycles(latched_cm_r);
   assign trig_rise_s = trig_s & ~trig_prev_r;

   // Two-flop synchronizer for the asynchronous trigger plus one history flop for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_r     <= 1'b0;
         trig_s      <= 1'b0;
         trig_prev_r <= 1'b0;
      end else begin
         sync1_r     <= bus.trigger;
         trig_s      <= sync1_r;
         trig_prev_r <= trig_s;
      end
   end

   // Next-state, counter and latch logic; one shared counter times every phase.
   always_comb begin
      state_nxt_s   = state_r;
      cnt_nxt_s     = cnt_r;
      latched_nxt_s = latched_cm_r;
      short_nxt_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (trig_rise_s) begin
               state_nxt_s = ARMED;
               cnt_nxt_s   = 22'd0;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ARMED: begin
            if (trig_s) begin
               if (cnt_r < 22'(TRIG_MIN_CYCLES)) begin
                  cnt_nxt_s = cnt_r + 22'd1;
               end else begin
                  cnt_nxt_s = cnt_r;
               end
            end else if (cnt_r >= 22'(TRIG_MIN_CYCLES)) begin
               latched_nxt_s = bus.distance_cm;
               state_nxt_s   = BURST;
               cnt_nxt_s     = 22'(BURST_CYCLES - 1);
            end else begin
               short_nxt_s = 1'b1;
               state_nxt_s = IDLE;
               cnt_nxt_s   = 22'd0;
            end
         end
         BURST: begin
            if (cnt_r != 22'd0) begin
               cnt_nxt_s = cnt_r - 22'd1;
            end else if (echo_len_s == 22'd0) begin
               state_nxt_s = HOLDOFF;
               cnt_nxt_s   = 22'(HOLDOFF_CYCLES - 1);
            end else begin
               state_nxt_s = ECHO;
               cnt_nxt_s   = echo_len_s - 22'd1;
            end
         end
         ECHO: begin
            if (cnt_r != 22'd0) begin
               cnt_nxt_s = cnt_r - 22'd1;
            end else begin
               state_nxt_s = HOLDOFF;
               cnt_nxt_s   = 22'(HOLDOFF_CYCLES - 1);
            end
         end
         HOLDOFF: begin
            if (cnt_r != 22'd0) begin
               cnt_nxt_s = cnt_r - 22'd1;
            end else begin
               state_nxt_s = IDLE;
               cnt_nxt_s   = 22'd0;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 22'd0;
         end
      endcase
   end

   // State register; outputs are decoded from the next state so they line up with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         cnt_r        <= 22'd0;
         latched_cm_r <= 9'd0;
         echo_r       <= 1'b0;
         busy_r       <= 1'b0;
         short_trig_r <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         cnt_r        <= cnt_nxt_s;
         latched_cm_r <= latched_nxt_s;
         echo_r       <= (state_nxt_s == ECHO);
         busy_r       <= (state_nxt_s != IDLE) && (state_nxt_s != ARMED);
         short_trig_r <= short_nxt_s;
      end
   end

   assign bus.echo       = echo_r;
   assign bus.busy       = busy_r;
   assign bus.short_trig = short_trig_r;

endmodule

// File: tb/tb_hcsr04_responder.sv
// Scoreboard bench for hcsr04_responder with scaled-down timing parameters.
// Expected echo widths are queued at stimulus time and checked on each echo fall.
module tb_hcsr04_responder;

   localparam int CPC   = 3;
   localparam int TMIN  = 20;
   localparam int BURST = 100;
   localparam int HOLD  = 400;
   localparam int MAXCM = 400;
   localparam int TMO   = 1900;

   logic clk = 1'b0;
   logic reset;

   hcsr04_responder_if bus_if ();

   hcsr04_responder #(
      .CYCLES_PER_CM   (CPC),
      .TRIG_MIN_CYCLES (TMIN),
      .BURST_CYCLES    (BURST),
      .HOLDOFF_CYCLES  (HOLD),
      .MAX_CM          (MAXCM),
      .TIMEOUT_CYCLES  (TMO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   int test_cnt   = 0;
   int fail_cnt   = 0;
   int exp_q[$];
   int pushed_cnt = 0;
   int echo_cnt   = 0;
   int short_cnt  = 0;
   int short_hi   = 0;
   int busy_gap   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      test_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference echo width straight from the distance/timing rules.
   function automatic int exp_echo(input int cm);
`ifdef HCSR04_RESP_RANGE_CHECK_EN
      if (cm == 0 || cm > MAXCM) return TMO;
`endif
      return cm * CPC;
   endfunction

   task automatic expect_echo(input int cm);
      if (exp_echo(cm) > 0) begin
         exp_q.push_back(exp_echo(cm));
         pushed_cnt++;
      end
   endtask

   task automatic pulse_trig(input int w, input int cm);
      @(negedge clk);
      bus_if.distance_cm = 9'(cm);
      bus_if.trigger     = 1'b1;
      repeat (w) @(negedge clk);
      bus_if.trigger = 1'b0;
   endtask

   task automatic wait_lvl(input string tag, input bit use_busy, input logic lvl,
                           input int limit, output int n);
      logic cur;
      n   = 0;
      cur = ~lvl;
      while (cur !== lvl && n < limit) begin
         @(negedge clk);
         n++;
         cur = use_busy ? bus_if.busy : bus_if.echo;
      end
      if (cur !== lvl) check_eq({tag, "_timeout"}, 32'(cur), 32'(lvl));
   endtask

   // Monitor: measures each echo pulse, pops the scoreboard, tracks short_trig pulses.
   initial begin : monitor
      int width;
      bit in_echo;
      bit short_prev;
      width      = 0;
      in_echo    = 1'b0;
      short_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            width   = 0;
            in_echo = 1'b0;
         end else if (bus_if.echo) begin
            width++;
            in_echo = 1'b1;
            if (!bus_if.busy) busy_gap++;
         end else if (in_echo) begin
            echo_cnt++;
            if (exp_q.size() == 0) check_eq("unexpected_echo_width", width, 0);
            else check_eq("echo_width", width, exp_q.pop_front());
            in_echo = 1'b0;
            width   = 0;
         end
         if (bus_if.short_trig) short_hi++;
         if (bus_if.short_trig && !short_prev) short_cnt++;
         short_prev = bus_if.short_trig;
      end
   end

   // Full measurement of one accepted trigger whose echo is expected.
   task automatic run_echo(input string tag, input int cm);
      int n;
      expect_echo(cm);
      pulse_trig(30, cm);
      wait_lvl({tag, "_rise"}, 1'b0, 1'b1, BURST + 50, n);
      check_eq({tag, "_delay"}, n, BURST + 3);
      wait_lvl({tag, "_fall"}, 1'b0, 1'b0, TMO + 10, n);
      wait_lvl({tag, "_idle"}, 1'b1, 1'b0, HOLD + 50, n);
      check_eq({tag, "_holdoff"}, n, HOLD);
      repeat (10) @(negedge clk);
   endtask

   initial begin : stim
      int n;
      int n2;
      int dist_tbl[4];
      dist_tbl = '{450, 400, 1, 0};
      reset              = 1'b1;
      bus_if.trigger     = 1'b0;
      bus_if.distance_cm = 9'd0;
      repeat (3) @(negedge clk);
      check_eq("rst_echo", bus_if.echo, 1'b0);
      check_eq("rst_busy", bus_if.busy, 1'b0);
      check_eq("rst_short", bus_if.short_trig, 1'b0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      // Nominal ranging cycle.
      run_echo("nominal", 10);
      check_eq("nominal_busy_gap", busy_gap, 0);

      // Too-short trigger is rejected with a single-cycle pulse.
      pulse_trig(10, 10);
      repeat (20) @(negedge clk);
      check_eq("short_count", short_cnt, 1);
      check_eq("short_width", short_hi, 1);
      check_eq("short_busy", bus_if.busy, 1'b0);
      check_eq("short_no_echo", echo_cnt, 1);

      // Distance changes after latching, plus a trigger held across holdoff end.
      expect_echo(10);
      pulse_trig(30, 10);
      repeat (10) @(negedge clk);
      bus_if.distance_cm = 9'd150;
      wait_lvl("latch_rise", 1'b0, 1'b1, BURST + 50, n);
      check_eq("latch_delay", n + 10, BURST + 3);
      repeat (5) @(negedge clk);
      bus_if.distance_cm = 9'd200;
      wait_lvl("latch_fall", 1'b0, 1'b0, TMO + 10, n);
      repeat (50) @(negedge clk);
      bus_if.trigger = 1'b1;
      wait_lvl("latch_idle", 1'b1, 1'b0, HOLD + 50, n);
      check_eq("latch_holdoff", n + 50, HOLD);
      repeat (50) @(negedge clk);
      bus_if.trigger = 1'b0;
      repeat (BURST + 100) @(negedge clk);
      check_eq("held_trig_busy", bus_if.busy, 1'b0);
      check_eq("held_trig_echoes", echo_cnt, 2);

      // Reset in the middle of an echo.
      pulse_trig(30, 10);
      wait_lvl("rst_mid_rise", 1'b0, 1'b1, BURST + 50, n);
      repeat (15) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check_eq("rst_mid_echo", bus_if.echo, 1'b0);
      check_eq("rst_mid_busy", bus_if.busy, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      check_eq("rst_no_resume", bus_if.echo, 1'b0);
      run_echo("post_rst", 7);

      // Range edges: over-range, max, minimum and zero distance.
      for (int i = 0; i < 4; i++) begin
         if (exp_echo(dist_tbl[i]) > 0) begin
            run_echo($sformatf("dist%0d", dist_tbl[i]), dist_tbl[i]);
         end else begin
            pulse_trig(30, dist_tbl[i]);
            wait_lvl("zero_busy_rise", 1'b1, 1'b1, 20, n);
            wait_lvl("zero_busy_fall", 1'b1, 1'b0, BURST + HOLD + 50, n2);
            check_eq("zero_busy_len", n + n2, BURST + HOLD + 3);
            repeat (10) @(negedge clk);
         end
      end

      repeat (20) @(negedge clk);
      check_eq("queue_empty", exp_q.size(), 0);
      check_eq("echo_count", echo_cnt, pushed_cnt);
      check_eq("final_busy_gap", busy_gap, 0);
      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule
